// File: rtl/debounce_scheduler_pkg.sv
// Shared types and constants for the switch debounce / event scheduler block.
// Imported by the scheduler top and by anything decoding its event port.
package debounce_scheduler_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } evt_state_e;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] idx;

  // NOTE: every variable written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = CW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/up_counter.sv
// Free-running up counter with synchronous clear and enable.
// Used as the shared sample-tick source for the debouncer.
module up_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (clr)      count <= '0;
    else if (count_en) count <= count + 1'b1;
  end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces N switches off one shared sample tick and serialises their debounced
// edges as press/release events over a valid/ready port with round-robin fairness.
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int N      = 4,
  parameter int WIDTH  = 16,
  parameter int WAIT   = 10000,
  parameter int STABLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in,
  output logic [N-1:0]         state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [$clog2(N)-1:0] evt_chan,
  output logic                 evt_level,
  output logic [N-1:0]         ovf,
  input  logic                 ovf_clr
);

  localparam int CW = $clog2(N);
  localparam int SW = $clog2(STABLE + 1);

  logic [WIDTH-1:0] count;
  logic             tick;

  logic [N-1:0]  sync1, sync2;
  logic [SW-1:0] stab [N];
  logic [N-1:0]  accept;
  logic [N-1:0]  pending, plevel;
  logic [N-1:0]  take_mask;

  evt_state_e    fsm, fsm_next;
  logic [CW-1:0] ptr, ptr_next, chan_next, grant;
  logic          level_next, take, any;

  up_counter #(.WIDTH(WIDTH)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .count_en (1'b1),
    .clr      (tick),
    .count    (count)
  );

  assign tick = (count == WIDTH'(WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  // A channel flips on the tick that brings its run of differing samples to STABLE.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++)
      accept[i] = tick && (sync2[i] != state[i]) && (stab[i] == SW'(STABLE - 1));
  end

  assign take_mask = take ? (N'(1) << grant) : '0;

  // NOTE: the stab array is small and its contents matter after reset, so it is
  // reset like any other register rather than treated as uninitialised storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= '0;
      pending <= '0;
      plevel  <= '0;
      ovf     <= '0;
      for (int i = 0; i < N; i++) stab[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (tick) begin
          if (sync2[i] == state[i] || accept[i]) stab[i] <= '0;
          else                                   stab[i] <= stab[i] + 1'b1;
        end
        if (accept[i]) plevel[i] <= sync2[i];
      end
      state   <= state ^ accept;
      pending <= (pending & ~take_mask) | accept;
      // An event just handed to the FSM this cycle is not lost, so it is no overflow.
      ovf     <= (ovf_clr ? '0 : ovf) | (accept & pending & ~take_mask);
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req   (pending),
    .ptr   (ptr),
    .grant (grant),
    .any   (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      ptr       <= '0;
      evt_chan  <= '0;
      evt_level <= 1'b0;
    end else begin
      fsm       <= fsm_next;
      ptr       <= ptr_next;
      evt_chan  <= chan_next;
      evt_level <= level_next;
    end
  end

  always_comb begin
    fsm_next   = fsm;
    ptr_next   = ptr;
    chan_next  = evt_chan;
    level_next = evt_level;
    take       = 1'b0;
    case (fsm)
      S_IDLE: begin
        if (any) begin
          take       = 1'b1;
          chan_next  = grant;
          level_next = plevel[grant];
          fsm_next   = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (evt_ready) begin
          fsm_next = S_IDLE;
          ptr_next = (evt_chan == CW'(N - 1)) ? '0 : evt_chan + 1'b1;
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  assign evt_valid = (fsm == S_PRESENT);

endmodule
